// File: rtl/floppy_pkg.sv
// Shared definitions for the floppy head-positioning logic: coil phase
// patterns, stepper FSM states and track-count sizing.
package floppy_pkg;

   localparam int TRK_W         = 7;
   localparam int DEF_MAX_TRACK = 79;

   // Full-step coil patterns, in inward order
   localparam logic [3:0] PHASE_0 = 4'b0011;
   localparam logic [3:0] PHASE_1 = 4'b0110;
   localparam logic [3:0] PHASE_2 = 4'b1100;
   localparam logic [3:0] PHASE_3 = 4'b1001;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SETTLE = 2'd2
   } state_t;

   function automatic logic [3:0] phase_pattern(input logic [1:0] idx);
      logic [3:0] pat;
      case (idx)
         2'd0:    pat = PHASE_0;
         2'd1:    pat = PHASE_1;
         2'd2:    pat = PHASE_2;
         default: pat = PHASE_3;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line, with a registered
// falling-edge pulse that lines up with the cycle the synced level drops.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic fall
);

   logic meta;

   // Shift the pin through two flops; flag a high-to-low move of the synced level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         fall <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         fall <= sync & ~meta;
      end
   end

endmodule

// File: rtl/head_stepper.sv
// Floppy head stepper: turns bus STEP/DIRECTION pulses into timed full-step
// coil phases for a ULN2003 driver, tracks the head position and
// recalibrates it from the track-00 sensor.
module head_stepper
   import floppy_pkg::*;
#(
   parameter int STEP_CYC   = 150_000,
   parameter int SETTLE_CYC = 50_000,
   parameter int MAX_TRACK  = DEF_MAX_TRACK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             step,
   input  logic             dir,
   input  logic             tr0_sens,
   output logic [3:0]       coils,
   output logic [TRK_W-1:0] trk_count,
   output logic             busy,
   output logic             overrun
);

   localparam int CNT_MAX = (STEP_CYC > SETTLE_CYC) ? STEP_CYC : SETTLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [TRK_W-1:0] TRK_MAX     = TRK_W'(MAX_TRACK);

   logic             step_sync, step_fall;
   logic             dir_sync, dir_fall;
   logic             tr0_sync, tr0_fall;
   logic             unused_sync_bits;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             ignore_q, ignore_next;

   logic [1:0]       phase_idx, phase_next;
   logic [TRK_W-1:0] trk_next;
   logic             pend_valid, pend_dir;

   logic             req, slot_end, take_pend, req_used;
   logic             start, start_dir, start_ignored;
   logic [3:0]       coils_next;
   logic             busy_next;

   sync_edge u_step_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (step),
      .sync (step_sync),
      .fall (step_fall)
   );

   sync_edge u_dir_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (dir),
      .sync (dir_sync),
      .fall (dir_fall)
   );

   sync_edge u_tr0_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (tr0_sens),
      .sync (tr0_sync),
      .fall (tr0_fall)
   );

   // Only the step edge and the dir/tr0 levels are used
   assign unused_sync_bits = &{1'b0, step_sync, dir_fall, tr0_fall};

   // Decide whether a step starts this cycle, from the pending slot or a fresh request
   always_comb begin
      req       = step_fall & en;
      slot_end  = ((state == SETTLE) && (cnt == '0)) || ((state == DRIVE) && ignore_q);
      take_pend = slot_end && pend_valid && en;
      start     = 1'b0;
      start_dir = dir_sync;
      if (state == IDLE) begin
         start = req;
      end else if (take_pend) begin
         start     = 1'b1;
         start_dir = pend_dir;
      end else if (slot_end) begin
         start = req;
      end
      req_used      = start && !take_pend;
      start_ignored = start && ((!start_dir && (trk_count == TRK_MAX)) ||
                                ( start_dir && tr0_sync));
   end

   // Phase and track effect of a starting step, plus track-00 recalibration in IDLE
   always_comb begin
      phase_next = phase_idx;
      trk_next   = trk_count;
      if (start && !start_ignored) begin
         if (start_dir) begin
            phase_next = phase_idx - 2'd1;
            if (trk_count != '0) begin
               trk_next = trk_count - TRK_W'(1);
            end
         end else begin
            phase_next = phase_idx + 2'd1;
            trk_next   = trk_count + TRK_W'(1);
         end
      end else if ((state == IDLE) && !start && tr0_sync) begin
         trk_next = '0;
      end
   end

   // FSM state register with the shared hold/settle down-counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ignore_q <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         ignore_q <= ignore_next;
      end
   end

   // Next-state logic: DRIVE holds the phase, SETTLE waits, ignored steps last one cycle
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      ignore_next = ignore_q;
      if (start) begin
         state_next  = DRIVE;
         cnt_next    = STEP_LOAD;
         ignore_next = start_ignored;
      end else begin
         case (state)
            DRIVE: begin
               if (ignore_q) begin
                  state_next  = IDLE;
                  ignore_next = 1'b0;
               end else if (cnt == '0) begin
                  state_next = SETTLE;
                  cnt_next   = SETTLE_LOAD;
               end else begin
                  cnt_next = cnt - CNT_W'(1);
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  state_next = IDLE;
               end else begin
                  cnt_next = cnt - CNT_W'(1);
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Output decode: coils energised while selected or mid-step, busy outside IDLE
   always_comb begin
      busy_next  = (state_next != IDLE);
      coils_next = (en || busy_next) ? phase_pattern(phase_next) : 4'b0000;
   end

   // Datapath registers: phase, track, pending slot, overrun flag and outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_idx  <= 2'd0;
         trk_count  <= '0;
         pend_valid <= 1'b0;
         pend_dir   <= 1'b0;
         overrun    <= 1'b0;
         coils      <= 4'b0000;
         busy       <= 1'b0;
      end else begin
         phase_idx <= phase_next;
         trk_count <= trk_next;
         coils     <= coils_next;
         busy      <= busy_next;
         if (take_pend) begin
            pend_valid <= 1'b0;
         end
         if (req && !req_used) begin
            if (pend_valid && !take_pend) begin
               overrun <= 1'b1;
            end else begin
               pend_valid <= 1'b1;
               pend_dir   <= dir_sync;
            end
         end
         if (!en) begin
            pend_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_head_stepper.sv
// Self-checking bench for head_stepper with short hold/settle times.
module tb_head_stepper;

   localparam int STEP_CYC   = 8;
   localparam int SETTLE_CYC = 4;
   localparam int MAX_TRK    = 79;
   localparam logic [3:0] PAT [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       step;
   logic       dir;
   logic       tr0_sens;
   logic [3:0] coils;
   logic [6:0] trk_count;
   logic       busy;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   // Reference head position and coil phase
   int m_track;
   int m_phase;
   bit m_tr0;

   int run_len    = 0;
   int last_width = 0;

   head_stepper #(
      .STEP_CYC   (STEP_CYC),
      .SETTLE_CYC (SETTLE_CYC),
      .MAX_TRACK  (MAX_TRK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .step      (step),
      .dir       (dir),
      .tr0_sens  (tr0_sens),
      .coils     (coils),
      .trk_count (trk_count),
      .busy      (busy),
      .overrun   (overrun)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Measure the width of each busy pulse on the falling clock edge
   always @(negedge clk) begin
      if (busy === 1'b1) begin
         run_len++;
      end else begin
         if (run_len != 0) last_width = run_len;
         run_len = 0;
      end
   end

   // Hard stop if the bench itself stalls
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Behavioural effect of one accepted step on the head
   task automatic modelStep(input bit outward, output bit executed);
      executed = 1'b0;
      if (!outward && m_track == MAX_TRK) begin
         executed = 1'b0;
      end else if (outward && m_tr0) begin
         executed = 1'b0;
      end else begin
         executed = 1'b1;
         m_phase  = outward ? (m_phase + 3) % 4 : (m_phase + 1) % 4;
         if (!outward) m_track = m_track + 1;
         else if (m_track > 0) m_track = m_track - 1;
      end
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, " idle_timeout"}, 32'(n < 200), 1);
      tick(1);
   endtask

   // One isolated step pulse (2 cycles low) issued from IDLE, with latency and width checks
   task automatic applyStimulus(input bit outward, input string tag);
      bit         executed;
      logic [3:0] prev_pat;
      prev_pat = (en) ? PAT[m_phase] : 4'b0000;
      modelStep(outward, executed);
      dir  = outward;
      step = 1'b0;
      tick(1);
      tick(1);
      step = 1'b1;
      @(negedge clk);
      checkOutput({tag, " busy_early"}, busy, 0);
      checkOutput({tag, " coils_early"}, coils, prev_pat);
      @(negedge clk);
      checkOutput({tag, " coils"}, coils, PAT[m_phase]);
      checkOutput({tag, " trk"}, trk_count, m_track);
      checkOutput({tag, " busy"}, busy, 1);
      waitIdle(tag);
      checkOutput({tag, " busy_width"}, last_width, executed ? STEP_CYC + SETTLE_CYC : 1);
   endtask

   initial begin
      bit seen;
      rst = 1'b0; en = 1'b0; step = 1'b1; dir = 1'b0; tr0_sens = 1'b0;
      m_track = 0; m_phase = 0; m_tr0 = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset coils", coils, 0);
      checkOutput("reset trk", trk_count, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset overrun", overrun, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      en  = 1'b1;
      tick(3);
      @(negedge clk);
      checkOutput("enabled coils", coils, PAT[0]);
      checkOutput("enabled trk", trk_count, 0);
      checkOutput("enabled busy", busy, 0);
      tick(1);

      // Spaced inward steps, then up to track 5
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, "inward");
         tick(4);
      end

      // Burst: second step goes to the pending slot, third is dropped
      begin
         bit ex;
         modelStep(1'b0, ex);
         modelStep(1'b0, ex);
         dir = 1'b0;
         step = 1'b0; tick(2); step = 1'b1; tick(1);
         step = 1'b0; tick(2); step = 1'b1; tick(1);
         step = 1'b0; tick(2); step = 1'b1;
         tick(1);
         waitIdle("burst");
         checkOutput("burst busy_width", last_width, 2 * (STEP_CYC + SETTLE_CYC));
         checkOutput("burst trk", trk_count, m_track);
         checkOutput("burst coils", coils, PAT[m_phase]);
         checkOutput("burst overrun", overrun, 1);
         tick(3);
      end

      // Randomized isolated steps in both directions
      for (int i = 0; i < 25; i++) begin
         applyStimulus($urandom_range(0, 2) == 0, "random");
         tick($urandom_range(1, 6));
      end

      // Track-00 sensor: recalibrate in IDLE, block outward steps, then recal step at 0
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, "pre_tr0");
      tr0_sens = 1'b1;
      m_tr0    = 1'b1;
      m_track  = 0;
      tick(3);
      @(negedge clk);
      checkOutput("tr0 force trk", trk_count, 0);
      tick(1);
      applyStimulus(1'b1, "tr0 blocked");
      tr0_sens = 1'b0;
      m_tr0    = 1'b0;
      tick(3);
      applyStimulus(1'b1, "recal");

      // Run to the last track, then one more inward step is refused
      while (m_track < MAX_TRK) applyStimulus(1'b0, "climb");
      applyStimulus(1'b0, "max blocked");
      en = 1'b0;
      tick(2);
      @(negedge clk);
      checkOutput("disabled coils", coils, 0);
      tick(1);
      en = 1'b1;
      tick(2);
      @(negedge clk);
      checkOutput("reenabled coils", coils, PAT[m_phase]);
      tick(1);

      // Reset in the middle of DRIVE
      dir = 1'b0;
      step = 1'b0; tick(2); step = 1'b1;
      tick(3);
      rst = 1'b0;
      #1;
      checkOutput("midreset coils", coils, 0);
      checkOutput("midreset trk", trk_count, 0);
      checkOutput("midreset busy", busy, 0);
      checkOutput("midreset overrun", overrun, 0);
      m_track = 0;
      m_phase = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      tick(3);
      @(negedge clk);
      checkOutput("postreset coils", coils, PAT[0]);
      tick(1);

      // Step pulses while deselected must be ignored
      en   = 1'b0;
      seen = 1'b0;
      tick(2);
      for (int i = 0; i < 18; i++) begin
         step = ((i % 6) < 2) ? 1'b0 : 1'b1;
         @(negedge clk);
         seen = seen | busy;
         @(posedge clk); #1;
      end
      checkOutput("deselected busy", seen, 0);
      checkOutput("deselected trk", trk_count, 0);
      checkOutput("deselected coils", coils, 0);
      en = 1'b1;
      tick(3);
      @(negedge clk);
      checkOutput("deselected phase kept", coils, PAT[m_phase]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/head_stepper.md
# head_stepper

Head-positioning stage between the floppy bus control logic and the ULN2003 4-coil stepper driver. Converts active-low bus STEP pulses and DIRECTION into timed full-step coil phases. Enforces per-step hold and settle times and maintains the current track count. Recalibrates the count to zero from the track-00 sensor.

## Interface

Parameters:
- `STEP_CYC`, 150_000: cycles each new coil phase is held before settle (3 ms at 50 MHz).
- `SETTLE_CYC`, 50_000: post-step settle cycles before the next step is accepted into DRIVE.
- `MAX_TRACK`, 79: highest legal track.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-low reset; one clock domain.
- `en`  in  1  drive selected (active-high, already decoded upstream).
- `step`  in  1  bus STEP, active-low, asynchronous to `clk`.
- `dir`  in  1  bus DIRECTION, asynchronous; 0 = inward (track+1), 1 = outward (track−1).
- `tr0_sens`  in  1  track-00 sensor, active-high, asynchronous.
- `coils`  out  4  coil drive pattern to the ULN2003.
- `trk_count`  out  7  current track, 0..MAX_TRACK.
- `busy`  out  1  step in progress (DRIVE or SETTLE).
- `overrun`  out  1  sticky: a step pulse was dropped; cleared only by reset.

## Operation

- `step`, `dir` and `tr0_sens` each pass through a 2-FF synchronizer. A falling edge of synced `step` while `en`=1 is a step request. `dir` is sampled on the same cycle as the edge.
- FSM states:
  - IDLE: on a request go to DRIVE; otherwise stay.
  - DRIVE: entry cycle applies the phase move; count STEP_CYC cycles, then go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles. At the end, go to DRIVE if a request is pending (pending clears), else go to IDLE.
- Requests arriving in DRIVE or SETTLE:
  - One request is held in a pending slot, with its `dir` latched.
  - A further request while pending is full is dropped and sets `overrun`.
- Phase sequence, index 0..3: 0011, 0110, 1100, 1001. Inward increments the index mod 4; outward decrements it mod 4.
- On DRIVE entry, handle the step by case:
  - Inward with `trk_count`=MAX_TRACK: ignored. No phase change, no count change, FSM returns to IDLE the next cycle.
  - Outward with synced `tr0_sens`=1: ignored in the same way.
  - Outward with `trk_count`=0 and `tr0_sens`=0 (recalibration): phase moves and the count stays 0.
  - Otherwise: phase moves and the count increments or decrements by 1.
- In IDLE, synced `tr0_sens`=1 forces `trk_count` to 0.
- `coils` shows the current phase pattern while `en`=1 or while not in IDLE. It is 0000 in IDLE with `en`=0. The phase index is retained while coils are off.
- If `en` falls mid-step, the in-flight DRIVE/SETTLE completes and the pending slot is cleared.
- All outputs are registered.

## Timing

- Reset values:
  - `coils`=0000, `trk_count`=0, `busy`=0, `overrun`=0.
  - Phase index 0, FSM in IDLE, pending empty.
- Latency: 3 `clk` cycles from `step` falling at the pin (sampled) to new `coils` and `trk_count` (2 sync + 1 edge/register).
- `busy` rises in the same cycle as the `coils` update. It stays high for exactly STEP_CYC+SETTLE_CYC cycles per executed step. Back-to-back pending steps keep `busy` continuously high.
- An ignored step (boundary case) raises `busy` for 1 cycle; `coils` and `trk_count` are unchanged.
- Minimum `step` low width is 2 `clk` cycles.
- Asserting reset mid-step immediately returns all state to the reset values.

## Structure

- Shared package `floppy_pkg`:
  - phase pattern constants (4×4 bits)
  - FSM state typedef (IDLE, DRIVE, SETTLE)
  - default MAX_TRACK
  - track-count width (7)
- Sub-module `sync_edge`: 2-FF synchronizer with registered falling-edge pulse output. Instantiated for `step`; plain sync instances for `dir` and `tr0_sens`.
- One shared down-counter sized for max(STEP_CYC, SETTLE_CYC), reloaded on each state entry.

## Test plan

Run with STEP_CYC=8, SETTLE_CYC=4.

1. Reset then `en`=1, no step → `coils`=0011, `trk_count`=0, `busy`=0.
2. Three inward steps spaced 20 cycles → `coils` 0110, 1100, 1001; `trk_count` 1, 2, 3; each `busy` pulse is 12 cycles wide.
3. Two steps 3 cycles apart, then a third 2 cycles later, all inward from track 5 → `trk_count` reaches 7 (second step served from pending); third step dropped; `overrun`=1; `busy` stays high for 24 cycles.
4. Outward step with `tr0_sens`=1 at track 0 → `coils` and `trk_count` unchanged, 1-cycle `busy`. Force `trk_count`=4 then raise `tr0_sens` in IDLE → `trk_count`=0 within 3 cycles.
5. Inward steps up to track 79, then one more → count stays 79, phase unchanged. `en`=0 in IDLE → `coils`=0000; `en`=1 again → previous pattern restored.
6. Assert `rst` during DRIVE → outputs at reset values immediately. `step` pulses while `en`=0 → no response.
